evt_encoder: RTL

Converts a stream of pixel-change and external-trigger events into 32-bit EVT 2.0 words on an AXI-Stream master, packetised with `tlast`. It is the transmit-side counterpart of the event decoder. It produces the word format the decoder consumes, so it serves as the camera-emulation source for closed-loop bring-up and regression of the event pipeline.

---
 rtl/evt_encoder_if.sv | 10 +
 rtl/evt_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/evt_encoder_if.sv
// AXI-Stream link carrying EVT 2.0 words out of evt_encoder.
interface evt_encoder_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/evt_encoder.sv
// Packs CD / external-trigger events into EVT 2.0 words with TIME_HIGH insertion,
// fixed-size tlast packets and an idle flush. Define EVT_ENCODER_TRIGGER_EN to emit EXT_TRIGGER words.
//
// state   | meaning
// IDLE    | accepting events, output register free or draining; idle flush runs here
// HOLD    | a TIME_HIGH was loaded, the accepted event waits in the hold register
module evt_encoder #(
  parameter int unsigned PACKET_WORDS = 256,
  parameter int unsigned FLUSH_TICKS  = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic        evt_is_trig_i,
  input  logic [10:0] evt_x_i,
  input  logic [10:0] evt_y_i,
  input  logic        evt_pol_i,
  input  logic [4:0]  evt_id_i,
  input  logic [33:0] evt_ts_i,
  evt_encoder_if.master m00_axis
);

  localparam int unsigned WCNT_W = $clog2(PACKET_WORDS);
  localparam int unsigned IDLE_W = $clog2(FLUSH_TICKS + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PACKET_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_TICKS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [3:0] TYPE_TH   = 4'h8;
  localparam logic [3:0] TYPE_TRIG = 4'hA;

  logic [0:0]        state, state_d;
  logic              tvalid_q, tlast_q;
  logic [31:0]       tdata_q;
  logic [27:0]       th_last;
  logic              th_valid;
  logic [WCNT_W-1:0] word_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       hold_word;

  logic        out_free, accept, th_need, flush, pkt_last;
  logic        load, force_last, th_update, th_refresh;
  logic [31:0] load_word, evt_word;
  logic [27:0] ts_hi;

  assign ts_hi = evt_ts_i[33:6];

  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tlast  = tlast_q;

  assign out_free    = !tvalid_q || m00_axis.tready;
  assign evt_ready_o = rst_ni && (state == ST_IDLE) && out_free;
  assign accept      = evt_valid_i && evt_ready_o;
  assign th_need     = !th_valid || (ts_hi != th_last);
  assign flush       = (state == ST_IDLE) && !accept && (word_cnt != '0) &&
                       (idle_cnt == IDLE_MAX) && out_free;

`ifdef EVT_ENCODER_TRIGGER_EN
  always_comb begin
    evt_word = {3'b000, evt_pol_i, evt_ts_i[5:0], evt_x_i, evt_y_i};
    if (evt_is_trig_i)
      evt_word = {TYPE_TRIG, evt_ts_i[5:0], 9'd0, evt_id_i, 7'd0, evt_pol_i};
  end
`else
  // Trigger inputs stay on the port list so both builds share one pinout.
  logic unused_trig;
  assign unused_trig = ^{evt_is_trig_i, evt_id_i};

  always_comb begin
    evt_word = {3'b000, evt_pol_i, evt_ts_i[5:0], evt_x_i, evt_y_i};
  end
`endif

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    load_word  = evt_word;
    force_last = 1'b0;
    th_update  = 1'b0;
    th_refresh = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (th_need) begin
            load_word = {TYPE_TH, ts_hi};
            th_update = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (flush) begin
          load       = 1'b1;
          load_word  = {TYPE_TH, th_last};
          force_last = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          load = 1'b1;
          // A TIME_HIGH that closed the packet leaves th_valid clear: reopen with a fresh one.
          if (!th_valid) begin
            load_word  = {TYPE_TH, th_last};
            th_refresh = 1'b1;
          end else begin
            load_word = hold_word;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pkt_last = force_last || (word_cnt == WCNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      th_last   <= '0;
      th_valid  <= 1'b0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      hold_word <= '0;
    end else begin
      state <= state_d;

      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= load_word;
        tlast_q  <= pkt_last;
        word_cnt <= pkt_last ? '0 : word_cnt + WCNT_W'(1);
      end else if (m00_axis.tready) begin
        tvalid_q <= 1'b0;
      end

      if (th_update) begin
        th_last  <= ts_hi;
        th_valid <= 1'b1;
      end
      if (th_refresh)
        th_valid <= 1'b1;
      if (load && pkt_last)
        th_valid <= 1'b0;

      if (accept && th_need)
        hold_word <= evt_word;

      if (accept)
        idle_cnt <= '0;
      else if ((state == ST_IDLE) && (word_cnt != '0) && (idle_cnt != IDLE_MAX))
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

endmodule
